// File: rtl/prio_encoder8to3.sv
// prio_encoder8to3: 74148-style priority encoder; falling edges on active-low requests become pending events.
// Latency: capture 1 edge after req_n low, valid 1 edge later (+2 edges with PRIO_ENC_SYNC_EN defined).
// Backpressure: the presented code is held, with valid high, until ack; one idle cycle separates grants.
module prio_encoder8to3 #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ei_n,
  input  logic [N-1:0] req_n,
  input  logic         ack,
  output logic [W-1:0] code,
  output logic         valid,
  output logic [N-1:0] pending,
  output logic         eo_n
);

  // The code must be able to name every request line exactly.
  if (W != $clog2(N)) begin : g_bad_cfg
    $error("prio_encoder8to3: W must equal clog2(N)");
  end

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] req_prev_q, req_prev_d;
  logic [W-1:0] code_q, code_d;
  logic         valid_q, valid_d;

  logic [N-1:0] req_smp;
  logic [N-1:0] fall_vec;
  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;
  logic [W-1:0] top_idx;
  logic         any_pending;

`ifdef PRIO_ENC_SYNC_EN
  logic [N-1:0] sync1_q, sync1_d;
  logic [N-1:0] sync2_q, sync2_d;

  // Two-stage synchronizer in front of the edge detector for asynchronous request lines.
  always_comb begin
    sync1_d = req_n;
    sync2_d = sync1_q;
    req_smp = sync2_q;
  end

  // Synchronizer flops idle high so no spurious falling edge appears out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end
`else
  // Requests are already synchronous to clk; sample them directly.
  always_comb begin
    req_smp = req_n;
  end
`endif

  // Falling-edge detection; req_prev always tracks the line, captures only while enabled.
  always_comb begin
    req_prev_d = req_smp;
    fall_vec   = req_prev_q & ~req_smp;
    set_vec    = ei_n ? '0 : fall_vec;
  end

  // Highest-index pending bit; later (higher) indices overwrite lower ones.
  always_comb begin
    top_idx     = '0;
    any_pending = |pending_q;
    for (int i = 0; i < N; i++) begin
      if (pending_q[i]) begin
        top_idx = W'(i);
      end
    end
  end

  // Pending update: ack clears the presented bit, a new capture on the same bit wins.
  always_comb begin
    clr_vec = '0;
    if ((state_q == PRESENT) && !ei_n && ack) begin
      clr_vec[code_q] = 1'b1;
    end
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  // Presentation FSM: grant from IDLE, hold the code in PRESENT until ack or disable.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (!ei_n && any_pending) begin
          code_d  = top_idx;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        valid_d = 1'b1;
        // Disable withdraws the code without clearing its pending bit.
        if (ei_n || ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset drops any in-flight grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      req_prev_q <= '1;
      code_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      req_prev_q <= req_prev_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign pending = pending_q;
  // Cascade enable: low only when enabled and idle; follows ei_n while reset is held.
  assign eo_n    = rst_n ? (ei_n | any_pending | valid_q) : ei_n;

endmodule
